shift_register_piso: RTL and testbench

SHIFT_REGISTER_PISO -- requirements
Module: shift_register_piso

---
 rtl/shift_register_piso.sv | 146 ++++++++++++++
 tb/tb_shift_register_piso.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_register_piso.sv
// -----------------------------------------------------------------------------
// shift_register_piso
//
// Parallel-in / serial-out shift register with a small IDLE/SHIFT control FSM.
// A parallel word is accepted on a rising edge of C where LD=1 and RDY=1. It
// then streams out on SO for exactly WIDTH cycles, one bit per cycle, with SV
// marking valid bits.
//
// FS marks the first bit of a frame and LST marks the last bit. RDY is also
// asserted on the LST cycle. A new word loaded on that edge therefore follows
// the current frame with no idle gap.
//
// Parameters
//   WIDTH      parallel word width in bits (minimum 2)
//   MSB_FIRST  1: PI[WIDTH-1] is sent first, 0: PI[0] is sent first
//
// Ports
//   C    in   clock, all state changes on the rising edge
//   R    in   synchronous active-high reset, wins over LD
//   PI   in   parallel word to serialize, sampled only on an accept edge
//   LD   in   load request qualifying PI
//   RDY  out  a word can be accepted on the coming edge
//   SO   out  serial data
//   SV   out  SO carries a valid frame bit
//   FS   out  first bit of frame strobe
//   LST  out  last bit of frame strobe
// -----------------------------------------------------------------------------
module shift_register_piso #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] PI,
  input  logic             LD,
  output logic             RDY,
  output logic             SO,
  output logic             SV,
  output logic             FS,
  output logic             LST
);

  // The bit counter only has to reach WIDTH-1.
  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             in_shift;
  logic             last_bit;
  logic             ready;
  logic             accept;
  logic             head_bit;
  logic [WIDTH-1:0] shreg_adv;

  // The bit on SO always sits at the outgoing end of the register. Advancing
  // the register moves the next bit into that position. Vacated positions are
  // filled with zero, so a stale frame never leaks old data.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign head_bit  = shreg_q[WIDTH-1];
      assign shreg_adv = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign head_bit  = shreg_q[0];
      assign shreg_adv = {1'b0, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  assign in_shift = (state_q == SHIFT);
  assign last_bit = in_shift && (cnt_q == CNT_LAST);

  // Ready in IDLE, and also on the last bit of a frame, so frames can be
  // chained back to back.
  assign ready  = !in_shift || last_bit;
  assign accept = LD && ready;

  // Next-state and output logic. All outputs decode directly from registered
  // state, so the first bit is visible for the whole cycle after the accept
  // edge, and reset takes effect on outputs from the reset edge.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;

    RDY = ready;
    SV  = in_shift;
    SO  = in_shift ? head_bit : 1'b0;
    FS  = in_shift && (cnt_q == '0);
    LST = last_bit;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = PI;
          cnt_d   = '0;
        end
      end

      SHIFT: begin
        if (last_bit) begin
          if (accept) begin
            shreg_d = PI;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
          end
        end else begin
          // LD is ignored mid-frame because ready is low here.
          shreg_d = shreg_adv;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State, data and counter registers. Reset overrides any load on the same
  // edge and aborts a frame in progress.
  always_ff @(posedge C) begin
    if (R) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_shift_register_piso.sv
// -----------------------------------------------------------------------------
// tb_shift_register_piso
//
// Self-checking bench for shift_register_piso.
//
// The driver pushes the expected serial bits of every word it expects to be
// accepted into a queue. A negedge monitor pops one entry per valid cycle and
// checks SO, FS, LST and RDY. While the queue is empty, the monitor checks
// that the block sits idle.
//
// A left-shifting SIPO model captures SO whenever SV=1. One cycle after each
// LST, its contents must equal the sent word. A second instance with
// MSB_FIRST=0 checks LSB-first ordering.
// -----------------------------------------------------------------------------
module tb_shift_register_piso;

  logic       clk = 1'b0;
  logic       r   = 1'b1;
  logic       ld  = 1'b0;
  logic [7:0] pi  = 8'h00;
  logic       rdy, so, sv, fs, lst;

  logic       ld_l = 1'b0;
  logic [7:0] pi_l = 8'h00;
  logic       rdy_l, so_l, sv_l, fs_l, lst_l;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       so;
    logic       fs;
    logic       lst;
    logic       rdy;
    logic [7:0] word;
  } exp_t;

  exp_t sb_q[$];

  logic       mon_en    = 1'b0;
  logic [7:0] sipo      = 8'h00;
  logic       sipo_pend = 1'b0;
  logic [7:0] sipo_exp  = 8'h00;

  always #5 clk = ~clk;

  shift_register_piso #(.WIDTH(8), .MSB_FIRST(1)) dut (
    .C  (clk),
    .R  (r),
    .PI (pi),
    .LD (ld),
    .RDY(rdy),
    .SO (so),
    .SV (sv),
    .FS (fs),
    .LST(lst)
  );

  shift_register_piso #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .C  (clk),
    .R  (r),
    .PI (pi_l),
    .LD (ld_l),
    .RDY(rdy_l),
    .SO (so_l),
    .SV (sv_l),
    .FS (fs_l),
    .LST(lst_l)
  );

  // Counts one comparison and reports it if it does not match.
  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one cycle of inputs. The bench decides for itself whether the word
  // will be accepted: that happens only when no frame bits remain outstanding
  // after this cycle's monitor pop. Accepted words have their expected bits
  // queued right after the edge.
  task automatic applyStimulus(input logic ld_i, input logic [7:0] pi_i, input logic r_i);
    logic will_accept;
    ld = ld_i;
    pi = pi_i;
    r  = r_i;
    @(negedge clk);
    #1;
    will_accept = ld_i && !r_i && (sb_q.size() == 0);
    @(posedge clk);
    if (r_i) begin
      sb_q.delete();
    end else if (will_accept) begin
      for (int i = 0; i < 8; i++) begin
        exp_t e;
        e.so   = pi_i[7-i];
        e.fs   = (i == 0);
        e.lst  = (i == 7);
        e.rdy  = (i == 7);
        e.word = pi_i;
        sb_q.push_back(e);
      end
    end
    #1;
  endtask

  // Idle cycles with PI scrambled, to show a frame ignores later PI changes.
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'($urandom), 1'b0);
  endtask

  // Reference SIPO fed from SO.
  always @(posedge clk) begin
    if (r) sipo <= 8'h00;
    else if (sv) sipo <= {sipo[6:0], so};
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sipo_pend) begin
        checkOutput("sipo_word", sipo, sipo_exp);
        sipo_pend = 1'b0;
      end
      checkOutput("sv", 8'(sv), 8'(sb_q.size() > 0));
      if (sv && sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("so",  8'(so),  8'(e.so));
        checkOutput("fs",  8'(fs),  8'(e.fs));
        checkOutput("lst", 8'(lst), 8'(e.lst));
        checkOutput("rdy", 8'(rdy), 8'(e.rdy));
        if (e.lst) begin
          sipo_pend = 1'b1;
          sipo_exp  = e.word;
        end
      end else if (!sv) begin
        checkOutput("idle_rdy", 8'(rdy), 8'h01);
        checkOutput("idle_so",  8'(so),  8'h00);
        checkOutput("idle_fs",  8'(fs),  8'h00);
        checkOutput("idle_lst", 8'(lst), 8'h00);
      end
    end
  end

  initial begin
    logic [7:0] w;
    logic [7:0] word_l;

    $display("[TB] start");

    // Reset, with a load request that must be dropped.
    applyStimulus(1'b0, 8'h00, 1'b1);
    mon_en = 1'b1;
    applyStimulus(1'b1, 8'h77, 1'b1);
    idleCycles(2);

    // Single frame of A5, then back to idle.
    applyStimulus(1'b1, 8'hA5, 1'b0);
    idleCycles(10);

    // 3C followed by C3 loaded on the LST cycle: 16 contiguous bits.
    applyStimulus(1'b1, 8'h3C, 1'b0);
    idleCycles(7);
    applyStimulus(1'b1, 8'hC3, 1'b0);
    idleCycles(10);

    // A load request on the third bit of a 00 frame is ignored.
    applyStimulus(1'b1, 8'h00, 1'b0);
    idleCycles(2);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    idleCycles(10);

    // Reset on the fourth bit of F0 aborts the frame; 81 then sends cleanly.
    applyStimulus(1'b1, 8'hF0, 1'b0);
    idleCycles(3);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 8'h81, 1'b0);
    idleCycles(10);

    // Random words, sometimes chained back to back.
    for (int k = 0; k < 12; k++) begin
      w = 8'($urandom);
      applyStimulus(1'b1, w, 1'b0);
      idleCycles(7 + $urandom_range(0, 2));
    end
    idleCycles(3);

    // Bounded drain of any outstanding expected bits.
    for (int i = 0; i < 40 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) checkOutput("drain", 8'(sb_q.size()), 8'h00);
    idleCycles(2);

    // LSB-first instance: 01 must come out as 1 followed by seven 0s.
    @(negedge clk);
    checkOutput("lsb_idle_rdy", 8'(rdy_l), 8'h01);
    word_l = 8'h01;
    ld_l   = 1'b1;
    pi_l   = word_l;
    @(posedge clk);
    #1;
    ld_l = 1'b0;
    pi_l = 8'hFE;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("lsb_sv", 8'(sv_l), 8'h01);
      checkOutput($sformatf("lsb_so%0d", i), 8'(so_l), 8'(word_l[i]));
      checkOutput("lsb_fs", 8'(fs_l), 8'(i == 0));
    end
    @(negedge clk);
    checkOutput("lsb_done_sv", 8'(sv_l), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
